// File: rtl/timer_pkg.sv
// Shared definitions for the BCD MM:SS timers: digit widths, digit limits,
// countdown state encoding and the preset clamp helpers.
package timer_pkg;
   localparam int UNITS_W = 4;
   localparam int TENS_W  = 3;

   localparam logic [UNITS_W-1:0] UNITS_MAX = 4'd9;
   localparam logic [TENS_W-1:0]  TENS_MAX  = 3'd5;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} cd_state_t;

   typedef struct packed {
      logic [TENS_W-1:0]  mt;
      logic [UNITS_W-1:0] mu;
      logic [TENS_W-1:0]  st;
      logic [UNITS_W-1:0] su;
   } bcd_time_t;

   function automatic logic [UNITS_W-1:0] clamp_units(input logic [UNITS_W-1:0] d);
      return (d > UNITS_MAX) ? UNITS_MAX : d;
   endfunction

   function automatic logic [TENS_W-1:0] clamp_tens(input logic [TENS_W-1:0] d);
      return (d > TENS_MAX) ? TENS_MAX : d;
   endfunction
endpackage

// File: rtl/mod_n_down_counter.sv
// One BCD digit counting down modulo N; load beats enable, and borrow flags
// the wrap from 0 to N-1 so digits can be chained.
module mod_n_down_counter #(
   parameter int N = 10,
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count,
   output logic         borrow
);
   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (en) begin
         r_count <= (r_count == '0) ? W'(N - 1) : r_count - W'(1);
      end
   end

   assign count  = r_count;
   assign borrow = en && (r_count == '0);
endmodule

// File: rtl/mm_ss_countdown.sv
// MM:SS BCD countdown: FSM, preset clamp/register, zero detect and expiry pulse
// around a chain of four digit counters. All outputs are registered.
module mm_ss_countdown #(
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       load,
   input  logic       start,
   input  logic       pause,
   input  logic [3:0] preset_seconds_units,
   input  logic [2:0] preset_seconds_tens,
   input  logic [3:0] preset_minutes_units,
   input  logic [2:0] preset_minutes_tens,
   output logic [3:0] seconds_units,
   output logic [2:0] seconds_tens,
   output logic [3:0] minutes_units,
   output logic [2:0] minutes_tens,
   output logic       running,
   output logic       done,
   output logic       expired
);
   import timer_pkg::*;

   cd_state_t r_state, w_state_nxt;
   bcd_time_t r_preset, w_clamped, w_count, w_load_val;
   logic      r_expired;
   logic      w_cnt_load, w_dec, w_expire;
   logic      w_is_zero, w_is_one, w_preset_zero;
   logic      w_su_borrow, w_st_borrow, w_mu_borrow, w_unused_mt_borrow;

   always_comb begin
      w_clamped.mt = clamp_tens(preset_minutes_tens);
      w_clamped.mu = clamp_units(preset_minutes_units);
      w_clamped.st = clamp_tens(preset_seconds_tens);
      w_clamped.su = clamp_units(preset_seconds_units);
   end

   assign w_count       = '{mt: minutes_tens, mu: minutes_units, st: seconds_tens, su: seconds_units};
   assign w_is_zero     = (w_count == 14'd0);
   assign w_is_one      = (w_count == 14'd1);
   assign w_preset_zero = (r_preset == 14'd0);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_load  = 1'b0;
      w_load_val  = w_clamped;
      w_dec       = 1'b0;
      w_expire    = 1'b0;
      if (load) begin
         w_cnt_load  = 1'b1;
         w_state_nxt = IDLE;
      end else if (pause) begin
         if (r_state == RUN) w_state_nxt = PAUSE;
      end else if (start && r_state != RUN) begin
         unique case (r_state)
            IDLE:  if (!w_is_zero) w_state_nxt = RUN;
            PAUSE: w_state_nxt = RUN;
            DONE: begin
               if (!w_preset_zero) begin
                  w_cnt_load  = 1'b1;
                  w_load_val  = r_preset;
                  w_state_nxt = RUN;
               end
            end
            default: w_state_nxt = r_state;
         endcase
      end else if (tick && r_state == RUN) begin
         w_expire = w_is_one;
         // Reload replaces the final decrement so 00:00 is never displayed.
         if (w_is_one && AUTO_RELOAD) begin
            w_cnt_load = 1'b1;
            w_load_val = r_preset;
         end else begin
            w_dec = 1'b1;
            if (w_is_one) w_state_nxt = DONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_preset  <= '0;
         r_expired <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_expired <= w_expire;
         if (load) r_preset <= w_clamped;
      end
   end

   mod_n_down_counter #(.N(10), .W(UNITS_W)) u_su (
      .clk(clk), .reset(reset), .en(w_dec), .load(w_cnt_load),
      .load_val(w_load_val.su), .count(seconds_units), .borrow(w_su_borrow));

   mod_n_down_counter #(.N(6), .W(TENS_W)) u_st (
      .clk(clk), .reset(reset), .en(w_su_borrow), .load(w_cnt_load),
      .load_val(w_load_val.st), .count(seconds_tens), .borrow(w_st_borrow));

   mod_n_down_counter #(.N(10), .W(UNITS_W)) u_mu (
      .clk(clk), .reset(reset), .en(w_st_borrow), .load(w_cnt_load),
      .load_val(w_load_val.mu), .count(minutes_units), .borrow(w_mu_borrow));

   mod_n_down_counter #(.N(6), .W(TENS_W)) u_mt (
      .clk(clk), .reset(reset), .en(w_mu_borrow), .load(w_cnt_load),
      .load_val(w_load_val.mt), .count(minutes_tens), .borrow(w_unused_mt_borrow));

   assign running = (r_state == RUN);
   assign done    = (r_state == DONE);
   assign expired = r_expired;
endmodule
